packet_depacketizer: RTL and testbench

//  Receive end of the serdes packet link: reassembles one header packet plus N_PKTS data packets into a PAYLOAD_WIDTH word.

---
 rtl/depkt_pkg.sv | 20 ++
 rtl/depkt_payload_fifo.sv | 60 ++++++
 rtl/packet_depacketizer.sv | 131 +++++++++++++
 tb/tb_packet_depacketizer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/depkt_pkg.sv
// Shared definitions for the serdes packet depacketizer: header field positions,
// FSM state encoding and the packets-per-payload derivation.
package depkt_pkg;

  localparam int unsigned HDR_VLD_BIT   = 0;
  localparam int unsigned HDR_ID_BIT    = 1;
  localparam int unsigned HDR_NPKTS_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2
  } depkt_state_e;

  function automatic int unsigned calc_n_pkts(input int unsigned payload_w,
                                              input int unsigned packet_w);
    return payload_w / packet_w;
  endfunction

endpackage

// File: rtl/depkt_payload_fifo.sv
// First-word-fall-through payload FIFO with registered valid/almost-full flags.
// Simultaneous push and pop are both honoured, including when full.
module depkt_payload_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             valid,
  output logic             almost_full,
  output logic             push_ok_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  logic             pop_ok_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok_c  = pop & valid;
  assign push_ok_c = push & (~full_q | pop_ok_c);
  assign count_d   = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      valid       <= 1'b0;
      full_q      <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (pop_ok_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_ok_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      count_q     <= count_d;
      valid       <= (count_d != '0);
      full_q      <= (count_d == CNT_W'(DEPTH));
      almost_full <= (count_d >= CNT_W'(DEPTH - 1));
    end
  end

  // Storage is not reset; the head is masked until an entry is valid.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_c = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/packet_depacketizer.sv
// Serdes link receive side: reassembles header + N_PKTS data packets into a payload.
// Optional build macro DEPKT_ID_FILTER_EN discards frames whose header id differs from ID.
module packet_depacketizer
  import depkt_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH = 128,
  parameter int unsigned PACKET_WIDTH  = 16,
  parameter logic        ID            = 1'b0,
  parameter int unsigned N_PKTS_BITS   = 4,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PACKET_WIDTH-1:0]  packet_i,
  output logic                     packet_received_o,
  output logic                     buffer_af_o,
  output logic                     payload_valid_o,
  output logic [PAYLOAD_WIDTH-1:0] payload_o,
  input  logic                     payload_ack_i,
  output logic                     overflow_o,
  output logic                     hdr_err_o
);

  localparam int unsigned N_PKTS = calc_n_pkts(PAYLOAD_WIDTH, PACKET_WIDTH);
  localparam int unsigned IDX_W  = (N_PKTS > 1) ? $clog2(N_PKTS) : 1;
  localparam int unsigned CNT_W  = N_PKTS_BITS;

  depkt_state_e                          state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [N_PKTS-1:0][PACKET_WIDTH-1:0]   asm_q, asm_d;
  logic                                  id_q, id_d;
  logic                                  hdr_err_d;
  logic                                  push_c;
  logic                                  push_ok_c;
  logic                                  id_ok_c;
  logic [N_PKTS_BITS-1:0]                hdr_npkts_c;

  assign hdr_npkts_c = packet_i[HDR_NPKTS_LSB +: N_PKTS_BITS];

`ifdef DEPKT_ID_FILTER_EN
  assign id_ok_c = (id_q == ID);
`else
  // Id is latched but never gates delivery in this build.
  assign id_ok_c = (id_q == ID) | 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      asm_q             <= '0;
      id_q              <= 1'b0;
      hdr_err_o         <= 1'b0;
      packet_received_o <= 1'b0;
      overflow_o        <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      asm_q             <= asm_d;
      id_q              <= id_d;
      hdr_err_o         <= hdr_err_d;
      packet_received_o <= push_ok_c;
      if (push_c && !push_ok_c) overflow_o <= 1'b1;
    end
  end

  // Frame parsing; the last beat is merged combinationally so it is written the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    id_d      = id_q;
    hdr_err_d = 1'b0;
    push_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (packet_i[HDR_VLD_BIT]) begin
          if (hdr_npkts_c == N_PKTS_BITS'(N_PKTS)) begin
            state_d = DATA;
            cnt_d   = '0;
            id_d    = packet_i[HDR_ID_BIT];
          end else begin
            hdr_err_d = 1'b1;
            if (hdr_npkts_c != '0) begin
              state_d = DROP;
              cnt_d   = CNT_W'(hdr_npkts_c);
            end
          end
        end
      end
      DATA: begin
        asm_d[IDX_W'(cnt_q)] = packet_i;
        if (cnt_q == CNT_W'(N_PKTS - 1)) begin
          push_c  = id_ok_c;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DROP: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  depkt_payload_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAYLOAD_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_c),
    .push_data   (asm_d),
    .pop         (payload_ack_i),
    .head_c      (payload_o),
    .valid       (payload_valid_o),
    .almost_full (buffer_af_o),
    .push_ok_c   (push_ok_c)
  );

endmodule

// File: tb/tb_packet_depacketizer.sv
// Scoreboard bench for packet_depacketizer (128-bit payload, 16-bit packets, ID=0).
module tb_packet_depacketizer;

  logic         clk;
  logic         rst_n;
  logic [15:0]  packet_i;
  logic         packet_received_o;
  logic         buffer_af_o;
  logic         payload_valid_o;
  logic [127:0] payload_o;
  logic         payload_ack_i;
  logic         overflow_o;
  logic         hdr_err_o;

  int total, bad;
  int rx_seen, exp_rx, err_seen, exp_err;
  logic [127:0] sb [$];
  logic [127:0] mon_exp;
  bit filt;

  packet_depacketizer #(
    .PAYLOAD_WIDTH (128),
    .PACKET_WIDTH  (16),
    .ID            (1'b0),
    .N_PKTS_BITS   (4),
    .FIFO_DEPTH    (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .packet_i          (packet_i),
    .packet_received_o (packet_received_o),
    .buffer_af_o       (buffer_af_o),
    .payload_valid_o   (payload_valid_o),
    .payload_o         (payload_o),
    .payload_ack_i     (payload_ack_i),
    .overflow_o        (overflow_o),
    .hdr_err_o         (hdr_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the consumer takes the FIFO head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (packet_received_o) rx_seen++;
      if (hdr_err_o) err_seen++;
      if (payload_valid_o && payload_ack_i) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_payload act=%h exp=none", payload_o);
        end else begin
          mon_exp = sb.pop_front();
          chk("payload", payload_o, mon_exp);
        end
      end
    end
  end

  task automatic drive(input logic [15:0] p);
    @(posedge clk);
    #1;
    packet_i = p;
  endtask

  task automatic send_frame(input logic [15:0] hdr, input logic [15:0] base,
                            input logic [15:0] mult, input bit deliver, input bit ack_last);
    logic [127:0] e;
    logic [15:0]  b;
    e = '0;
    drive(hdr);
    for (int i = 0; i < 8; i++) begin
      b = 16'(base + (i + 1) * mult);
      e[i*16 +: 16] = b;
      drive(b);
      if (i == 7 && ack_last) payload_ack_i = 1'b1;
    end
    if (deliver) begin
      sb.push_back(e);
      exp_rx++;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    payload_ack_i = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !payload_valid_o) done = 1'b1;
    end
    chk("drain_done", 128'(done), 128'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rcv"},   128'(packet_received_o), 128'd0);
    chk({tag, "_af"},    128'(buffer_af_o),       128'd0);
    chk({tag, "_valid"}, 128'(payload_valid_o),   128'd0);
    chk({tag, "_data"},  payload_o,               128'd0);
    chk({tag, "_ovf"},   128'(overflow_o),        128'd0);
    chk({tag, "_herr"},  128'(hdr_err_o),         128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; rx_seen = 0; exp_rx = 0; err_seen = 0; exp_err = 0;
`ifdef DEPKT_ID_FILTER_EN
    filt = 1'b1;
`else
    filt = 1'b0;
`endif
    rst_n = 1'b0;
    packet_i = '0;
    payload_ack_i = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic frame, hand-computed payload and one-cycle latency
    payload_ack_i = 1'b1;
    sb.push_back(128'h8888_7777_6666_5555_4444_3333_2222_1111);
    exp_rx++;
    drive(16'h0021);
    for (int i = 1; i <= 8; i++) drive(16'(i * 16'h1111));
    drive(16'h0000);
    @(negedge clk);
    chk("lat_valid", 128'(payload_valid_o), 128'd1);
    chk("lat_rcv", 128'(packet_received_o), 128'd1);
    @(negedge clk);
    chk("rcv_pulse_end", 128'(packet_received_o), 128'd0);
    chk("rx_count_t1", 128'(rx_seen), 128'(exp_rx));

    // Bad n_pkts header: 3 beats skipped (one looks like a header), next frame intact
    drive(16'h000D);
    exp_err++;
    drive(16'h0021);
    drive(16'hFFFF);
    drive(16'h0001);
    send_frame(16'h0021, 16'h0E00, 16'h0101, 1'b1, 1'b0);
    drive(16'h0000);
    drain();
    chk("hdr_err_count", 128'(err_seen), 128'(exp_err));
    chk("rx_count_t3", 128'(rx_seen), 128'(exp_rx));

    // Id=1 frame, then id=0 frame back-to-back
    send_frame(16'h0023, 16'h3000, 16'h0003, !filt, 1'b0);
    send_frame(16'h0021, 16'h4000, 16'h0005, 1'b1, 1'b0);
    drive(16'h0000);
    drain();
    chk("rx_count_id", 128'(rx_seen), 128'(exp_rx));

    // Full FIFO with push and ack in the same cycle
    payload_ack_i = 1'b0;
    send_frame(16'h0021, 16'h5000, 16'h0007, 1'b1, 1'b0);
    send_frame(16'h0021, 16'h6000, 16'h0009, 1'b1, 1'b0);
    drive(16'h0000);
    @(negedge clk);
    chk("full_af", 128'(buffer_af_o), 128'd1);
    chk("full_valid", 128'(payload_valid_o), 128'd1);
    send_frame(16'h0021, 16'h7000, 16'h000B, 1'b1, 1'b1);
    drive(16'h0000);
    payload_ack_i = 1'b0;
    @(negedge clk);
    chk("pp_rcv", 128'(packet_received_o), 128'd1);
    chk("pp_af", 128'(buffer_af_o), 128'd1);
    chk("pp_ovf", 128'(overflow_o), 128'd0);
    drain();
    chk("rx_count_pp", 128'(rx_seen), 128'(exp_rx));

    // Overflow: third frame into a full FIFO is dropped
    payload_ack_i = 1'b0;
    send_frame(16'h0021, 16'h8000, 16'h0013, 1'b1, 1'b0);
    send_frame(16'h0021, 16'h9000, 16'h0017, 1'b1, 1'b0);
    drive(16'h0000);
    @(negedge clk);
    chk("ovf_pre_af", 128'(buffer_af_o), 128'd1);
    chk("ovf_pre", 128'(overflow_o), 128'd0);
    send_frame(16'h0021, 16'hA000, 16'h001D, 1'b0, 1'b0);
    drive(16'h0000);
    @(negedge clk);
    chk("ovf_set", 128'(overflow_o), 128'd1);
    chk("ovf_no_rcv", 128'(packet_received_o), 128'd0);
    chk("rx_count_ovf", 128'(rx_seen), 128'(exp_rx));
    drain();
    chk("ovf_sticky", 128'(overflow_o), 128'd1);

    // Reset mid-frame after beat 4
    drive(16'h0021);
    for (int i = 1; i <= 4; i++) drive(16'(i * 16'h0F0F));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    packet_i = '0;
    #2;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(16'h0021, 16'hB000, 16'h0021, 1'b1, 1'b0);
    drive(16'h0000);
    drain();
    chk("rx_count_rst", 128'(rx_seen), 128'(exp_rx));
    chk("hdr_err_final", 128'(err_seen), 128'(exp_err));
    chk("sb_empty", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
